// File: rtl/bwt_prefix_sorter.sv
// Burrows-Wheeler transform engine built on prefix-doubling suffix sorting.
// Each phase forms (rank[i], rank[i+k], i) keys, sorts them with an N-pass
// odd-even transposition network, and then re-ranks them. The engine stops
// when every rank is unique or when the doubled prefix covers the string.
// Linear mode treats positions past the end as rank 0. Cyclic mode wraps
// the index so that whole rotations are compared.
module bwt_prefix_sorter #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int IW = $clog2(N),
  parameter int RW = ((W + 1) > $clog2(N + 1)) ? (W + 1) : $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode_cyclic,
  input  logic [N*W-1:0]  string_in,
  output logic            busy,
  output logic            done,
  output logic [N*IW-1:0] sa_out,
  output logic [N*W-1:0]  bwt_out,
  output logic [IW-1:0]   primary_idx,
  output logic [3:0]      phases
);

  localparam int CW = IW + 1;  // width of k and of the pass/entry counter
  localparam int KW = IW + 2;  // width of i+k, wide enough never to wrap

  localparam logic [CW-1:0] LAST_C   = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] RANK_ONE = RW'(1);
  localparam logic [RW-1:0] N_RANK_C = RW'(N);
  localparam logic [KW-1:0] N_WIDE_C = KW'(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYS   = 3'd1,
    S_SORT   = 3'd2,
    S_RANK   = 3'd3,
    S_CHECK  = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  state_t state_r, state_s;

  logic [W-1:0]    char_r [N];
  logic            cyc_r;
  logic [RW-1:0]   rank_r [N];
  logic [RW-1:0]   r1_r   [N];
  logic [RW-1:0]   r2_r   [N];
  logic [IW-1:0]   id_r   [N];
  logic [CW-1:0]   k_r;
  logic [CW-1:0]   cnt_r;
  logic [RW-1:0]   bucket_r;
  logic [3:0]      phases_r;
  logic            busy_r;
  logic            done_r;
  logic [N*IW-1:0] sa_r;
  logic [N*W-1:0]  bwt_r;
  logic [IW-1:0]   prim_r;

  // Strict ordering of full keys; idx as the last field makes the order total.
  function automatic logic key_gt(
    input logic [RW-1:0] a1, input logic [RW-1:0] a2, input logic [IW-1:0] ai,
    input logic [RW-1:0] b1, input logic [RW-1:0] b2, input logic [IW-1:0] bi
  );
    return {a1, a2, ai} > {b1, b2, bi};
  endfunction

  // Second-key lookup: rank of position i+k, or 0 / wrapped index past the end.
  logic [KW-1:0] key_sum_s  [N];
  logic [KW-1:0] key_wrap_s [N];
  logic [RW-1:0] key_r2_s   [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      key_sum_s[i]  = KW'(i) + KW'(k_r);
      key_wrap_s[i] = key_sum_s[i] - N_WIDE_C;
      if (key_sum_s[i] < N_WIDE_C) begin
        key_r2_s[i] = rank_r[key_sum_s[i][IW-1:0]];
      end else if (cyc_r) begin
        key_r2_s[i] = rank_r[key_wrap_s[i][IW-1:0]];
      end else begin
        key_r2_s[i] = {RW{1'b0}};
      end
    end
  end

  // One odd-even transposition pass; the pass parity selects the pairs.
  logic [RW-1:0] srt_r1_s [N];
  logic [RW-1:0] srt_r2_s [N];
  logic [IW-1:0] srt_id_s [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      srt_r1_s[i] = r1_r[i];
      srt_r2_s[i] = r2_r[i];
      srt_id_s[i] = id_r[i];
    end
    for (int i = 0; i + 1 < N; i++) begin
      if ((i[0] == cnt_r[0]) &&
          key_gt(r1_r[i], r2_r[i], id_r[i], r1_r[i+1], r2_r[i+1], id_r[i+1])) begin
        srt_r1_s[i]   = r1_r[i+1];
        srt_r2_s[i]   = r2_r[i+1];
        srt_id_s[i]   = id_r[i+1];
        srt_r1_s[i+1] = r1_r[i];
        srt_r2_s[i+1] = r2_r[i];
        srt_id_s[i+1] = id_r[i];
      end else begin
        srt_id_s[i] = srt_id_s[i];  // pair already ordered or not in this pass
      end
    end
  end

  // Re-ranking step for sorted entry j: open a new bucket when the pair changes.
  logic [IW-1:0] rank_j_s;
  logic [IW-1:0] rank_p_s;
  logic [RW-1:0] bucket_s;
  always_comb begin
    rank_j_s = cnt_r[IW-1:0];
    if (cnt_r == {CW{1'b0}}) begin
      rank_p_s = rank_j_s;
      bucket_s = RANK_ONE;
    end else begin
      rank_p_s = rank_j_s - IW'(1);
      if ((r1_r[rank_j_s] != r1_r[rank_p_s]) || (r2_r[rank_j_s] != r2_r[rank_p_s])) begin
        bucket_s = bucket_r + RANK_ONE;
      end else begin
        bucket_s = bucket_r;
      end
    end
  end

  // Stop once every rank is unique or once the prefix length covers the string.
  logic finish_s;
  always_comb begin
    finish_s = (bucket_r == N_RANK_C) || ({k_r, 1'b0} >= N_WIDE_C);
  end

  // Derive the suffix array, the BWT column and the primary index from the sorted entries.
  logic [N*IW-1:0] fin_sa_s;
  logic [N*W-1:0]  fin_bwt_s;
  logic [IW-1:0]   fin_prim_s;
  logic [IW-1:0]   fin_src_s [N];
  always_comb begin
    fin_prim_s = {IW{1'b0}};
    for (int j = 0; j < N; j++) begin
      fin_sa_s[j*IW +: IW] = id_r[j];
      if (id_r[j] == {IW{1'b0}}) begin
        fin_src_s[j] = IW'(N - 1);
        fin_prim_s   = IW'(j);
      end else begin
        fin_src_s[j] = id_r[j] - IW'(1);
      end
      fin_bwt_s[j*W +: W] = char_r[fin_src_s[j]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_KEYS;
        else       state_s = S_IDLE;
      end
      S_KEYS: state_s = S_SORT;
      S_SORT: begin
        if (cnt_r == LAST_C) state_s = S_RANK;
        else                 state_s = S_SORT;
      end
      S_RANK: begin
        if (cnt_r == LAST_C) state_s = S_CHECK;
        else                 state_s = S_RANK;
      end
      S_CHECK: begin
        if (finish_s) state_s = S_FINISH;
        else          state_s = S_KEYS;
      end
      S_FINISH: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Datapath: latch inputs, build the keys, sort and re-rank them, then publish the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r    <= 1'b0;
      k_r      <= {CW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      bucket_r <= {RW{1'b0}};
      phases_r <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sa_r     <= {(N*IW){1'b0}};
      bwt_r    <= {(N*W){1'b0}};
      prim_r   <= {IW{1'b0}};
      for (int i = 0; i < N; i++) begin
        char_r[i] <= {W{1'b0}};
        rank_r[i] <= {RW{1'b0}};
        r1_r[i]   <= {RW{1'b0}};
        r2_r[i]   <= {RW{1'b0}};
        id_r[i]   <= {IW{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cyc_r    <= mode_cyclic;
            k_r      <= CNT_ONE;
            phases_r <= 4'd0;
            busy_r   <= 1'b1;
            for (int i = 0; i < N; i++) begin
              char_r[i] <= string_in[i*W +: W];
              rank_r[i] <= RW'(string_in[i*W +: W]) + RANK_ONE;
            end
          end
        end
        S_KEYS: begin
          cnt_r <= {CW{1'b0}};
          for (int i = 0; i < N; i++) begin
            r1_r[i] <= rank_r[i];
            r2_r[i] <= key_r2_s[i];
            id_r[i] <= IW'(i);
          end
        end
        S_SORT: begin
          cnt_r <= (cnt_r == LAST_C) ? {CW{1'b0}} : cnt_r + CNT_ONE;
          for (int i = 0; i < N; i++) begin
            r1_r[i] <= srt_r1_s[i];
            r2_r[i] <= srt_r2_s[i];
            id_r[i] <= srt_id_s[i];
          end
        end
        S_RANK: begin
          cnt_r                    <= (cnt_r == LAST_C) ? {CW{1'b0}} : cnt_r + CNT_ONE;
          bucket_r                 <= bucket_s;
          rank_r[id_r[rank_j_s]]   <= bucket_s;
        end
        S_CHECK: begin
          phases_r <= phases_r + 4'd1;
          if (!finish_s) k_r <= {k_r[CW-2:0], 1'b0};
        end
        S_FINISH: begin
          sa_r   <= fin_sa_s;
          bwt_r  <= fin_bwt_s;
          prim_r <= fin_prim_s;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign sa_out      = sa_r;
  assign bwt_out     = bwt_r;
  assign primary_idx = prim_r;
  assign phases      = phases_r;

endmodule

// File: tb/tb_bwt_prefix_sorter.sv
// Directed bench for bwt_prefix_sorter: three instances (N=6, N=4, N=8)
// exercise linear and cyclic runs, early termination, handshake and reset.
module tb_bwt_prefix_sorter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // N = 6 instance
  logic        st6, mc6, busy6, done6;
  logic [47:0] str6, bwt6;
  logic [17:0] sa6;
  logic [2:0]  pi6;
  logic [3:0]  ph6;

  // N = 4 instance
  logic        st4, mc4, busy4, done4;
  logic [31:0] str4, bwt4;
  logic [7:0]  sa4;
  logic [1:0]  pi4;
  logic [3:0]  ph4;

  // N = 8 instance
  logic        st8, mc8, busy8, done8;
  logic [63:0] str8, bwt8;
  logic [23:0] sa8;
  logic [2:0]  pi8;
  logic [3:0]  ph8;

  bwt_prefix_sorter #(.N(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .start(st6), .mode_cyclic(mc6), .string_in(str6),
    .busy(busy6), .done(done6), .sa_out(sa6), .bwt_out(bwt6),
    .primary_idx(pi6), .phases(ph6)
  );

  bwt_prefix_sorter #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .mode_cyclic(mc4), .string_in(str4),
    .busy(busy4), .done(done4), .sa_out(sa4), .bwt_out(bwt4),
    .primary_idx(pi4), .phases(ph4)
  );

  bwt_prefix_sorter #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .mode_cyclic(mc8), .string_in(str8),
    .busy(busy8), .done(done8), .sa_out(sa8), .bwt_out(bwt8),
    .primary_idx(pi8), .phases(ph8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run on the N=6 instance; optionally pulse start with a different string mid-run.
  task automatic run6(input logic [47:0] s, input logic m, input int disturb_at, output int n_done);
    str6 = s; mc6 = m; st6 = 1'b1;
    tick();
    st6 = 1'b0;
    check("busy6_after_start", {63'd0, busy6}, 64'd1);
    n_done = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == disturb_at) begin
        st6 = 1'b1; str6 = {6{8'h7a}}; mc6 = ~m;
      end else begin
        st6 = 1'b0;
      end
      if (done6) begin
        n_done = n;
        break;
      end
    end
    st6 = 1'b0;
  endtask

  task automatic run4(input logic [31:0] s, input logic m, output int n_done);
    str4 = s; mc4 = m; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    check("busy4_after_start", {63'd0, busy4}, 64'd1);
    n_done = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done4) begin
        n_done = n;
        break;
      end
    end
  endtask

  task automatic run8(input logic [63:0] s, input logic m, output int n_done);
    str8 = s; mc8 = m; st8 = 1'b1;
    tick();
    st8 = 1'b0;
    check("busy8_after_start", {63'd0, busy8}, 64'd1);
    n_done = -1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done8) begin
        n_done = n;
        break;
      end
    end
  endtask

  // Banana: sa=[5,3,1,0,4,2], bwt="nnbaaa", primary=3, phases=2, done at edge 29.
  task automatic banana_results(input string tag, input int n);
    check({tag, "_edge"},  64'(n), 64'd29);
    check({tag, "_sa"},    64'(sa6), 64'({3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd5}));
    check({tag, "_bwt"},   64'(bwt6), 64'("aaabnn"));
    check({tag, "_pidx"},  64'(pi6), 64'd3);
    check({tag, "_phases"}, 64'(ph6), 64'd2);
    check({tag, "_busy"},  64'(busy6), 64'd0);
  endtask

  int n_done;
  int done_seen;
  logic [47:0] banana;

  initial begin
    banana = "ananab";
    rst = 1'b1;
    st6 = 1'b0; mc6 = 1'b0; str6 = 48'd0;
    st4 = 1'b0; mc4 = 1'b0; str4 = 32'd0;
    st8 = 1'b0; mc8 = 1'b0; str8 = 64'd0;
    tick(); tick();

    // Reset state
    check("rst_busy6",   64'(busy6), 64'd0);
    check("rst_done6",   64'(done6), 64'd0);
    check("rst_sa6",     64'(sa6), 64'd0);
    check("rst_phases6", 64'(ph6), 64'd0);
    check("rst_busy4",   64'(busy4), 64'd0);
    check("rst_bwt8",    64'(bwt8), 64'd0);
    rst = 1'b0;
    tick();

    // Linear banana
    run6(banana, 1'b0, 0, n_done);
    banana_results("banana", n_done);
    tick();
    check("banana_done_single", 64'(done6), 64'd0);
    check("banana_sa_hold",     64'(sa6), 64'({3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd5}));

    // Start and string change during SORT must not disturb the run
    run6(banana, 1'b0, 5, n_done);
    banana_results("midrun", n_done);
    tick();
    check("midrun_done_single", 64'(done6), 64'd0);

    // Back-to-back: second start issued in the done cycle
    run6(banana, 1'b0, 0, n_done);
    banana_results("b2b_first", n_done);
    run6(banana, 1'b0, 0, n_done);
    banana_results("b2b_second", n_done);
    tick();

    // Cyclic abab
    run4("baba", 1'b1, n_done);
    check("abab_edge",   64'(n_done), 64'd21);
    check("abab_sa",     64'(sa4), 64'({2'd3, 2'd1, 2'd2, 2'd0}));
    check("abab_bwt",    64'(bwt4), 64'("aabb"));
    check("abab_pidx",   64'(pi4), 64'd0);
    check("abab_phases", 64'(ph4), 64'd2);
    tick();

    // Linear aaaa
    run4("aaaa", 1'b0, n_done);
    check("aaaa_edge",   64'(n_done), 64'd21);
    check("aaaa_sa",     64'(sa4), 64'({2'd0, 2'd1, 2'd2, 2'd3}));
    check("aaaa_bwt",    64'(bwt4), 64'("aaaa"));
    check("aaaa_pidx",   64'(pi4), 64'd3);
    check("aaaa_phases", 64'(ph4), 64'd2);
    tick();

    // All-distinct string terminates after one phase
    run8("abcdefgh", 1'b0, n_done);
    check("early_edge",   64'(n_done), 64'd19);
    check("early_sa",     64'(sa8), 64'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));
    check("early_bwt",    64'(bwt8), 64'("ahgfedcb"));
    check("early_pidx",   64'(pi8), 64'd7);
    check("early_phases", 64'(ph8), 64'd1);
    tick();

    // Reset during RANK (edges 8..13 of the first phase for N=6)
    str6 = banana; mc6 = 1'b0; st6 = 1'b1;
    tick();
    st6 = 1'b0;
    repeat (10) tick();
    check("prerst_busy6", 64'(busy6), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_busy",   64'(busy6), 64'd0);
    check("midrst_done",   64'(done6), 64'd0);
    check("midrst_sa",     64'(sa6), 64'd0);
    check("midrst_bwt",    64'(bwt6), 64'd0);
    check("midrst_pidx",   64'(pi6), 64'd0);
    check("midrst_phases", 64'(ph6), 64'd0);
    rst = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done6) done_seen++;
    end
    check("midrst_no_done", 64'(done_seen), 64'd0);

    // A fresh run after the abort matches the first result
    run6(banana, 1'b0, 0, n_done);
    banana_results("post_rst", n_done);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
